// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back write-allocate data cache with a word-serial refill/evict port
module dcache_wb #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [31:0]           WriteData,
    input  logic [2:0]            funct3,
    output logic [31:0]           output_data,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);
    localparam int BW = $clog2(LINE_WORDS);
    localparam int OW = BW + 2;
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = ADDR_WIDTH - OW - IW;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t               state_q;
    logic [BW-1:0]        beat_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [BW-1:0] woff;
    logic [1:0]    lane;
    logic          is_st;
    logic          is_ld;
    logic          op_ok;
    logic          mis;
    logic          access;
    logic          hit;
    logic          last;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic [31:0]   wfill;
    logic [31:0]   mask;
    logic [31:0]   merged;
    logic [3:0]    be;

    // Address split, access decode, hit detection, load extraction and store merge
    always_comb begin
        tag      = addr[ADDR_WIDTH-1:OW+IW];
        idx      = addr[OW+IW-1:OW];
        woff     = addr[OW-1:2];
        lane     = addr[1:0];
        is_st    = MemWrite;
        is_ld    = MemRead & ~MemWrite;
        op_ok    = (is_st & ~funct3[2] & (funct3[1:0] != 2'b11))
                 | (is_ld & (funct3[1:0] != 2'b11) & ~(funct3[2] & funct3[1]));
        mis      = op_ok & (((funct3[1:0] == 2'b01) & lane[0]) | ((funct3[1:0] == 2'b10) & (lane != 2'b00)));
        access   = op_ok & ~mis;
        hit      = valid_q[idx] & (tag_q[idx] == tag);
        word     = data_q[idx][woff];
        shifted  = word >> {lane, 3'b000};
        load_val = funct3 == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]}
                 : funct3 == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]}
                 : funct3 == 3'b100 ? {24'b0, shifted[7:0]}
                 : funct3 == 3'b101 ? {16'b0, shifted[15:0]}
                 : word;
        be       = funct3[1:0] == 2'b00 ? 4'b0001 << lane
                 : funct3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011)
                 : 4'b1111;
        wfill    = funct3[1:0] == 2'b00 ? {4{WriteData[7:0]}}
                 : funct3[1:0] == 2'b01 ? {2{WriteData[15:0]}}
                 : WriteData;
        mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merged   = (word & ~mask) | (wfill & mask);
        last     = beat_q == BW'(LINE_WORDS - 1);
    end

    // Pipeline-facing and memory-facing outputs; the victim tag addresses writeback beats
    always_comb begin
        stall       = ~reset & ((state_q != IDLE) | (access & ~hit));
        misaligned  = ~reset & mis;
        output_data = (~reset & (state_q == IDLE) & access & hit & is_ld) ? load_val : 32'b0;
        mem_req     = mem_req_q;
        mem_we      = mem_we_q;
        mem_addr    = {state_q == WRITEBACK ? tag_q[idx] : tag, idx, beat_q, 2'b00};
        mem_wdata   = data_q[idx][beat_q];
    end

    // Controller: miss handling, beat counting and line metadata
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access & ~hit) begin
                        state_q   <= (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : REFILL;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= valid_q[idx] & dirty_q[idx];
                    end else if (access & is_st) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        beat_q <= beat_q + 1'b1;
                        if (last) begin
                            dirty_q[idx] <= 1'b0;
                            mem_we_q     <= 1'b0;
                            state_q      <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        beat_q <= beat_q + 1'b1;
                        if (last) begin
                            tag_q[idx]   <= tag;
                            valid_q[idx] <= 1'b1;
                            dirty_q[idx] <= 1'b0;
                            mem_req_q    <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line data: refill beats and store-hit merges
    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_ack)
            data_q[idx][beat_q] <= mem_rdata;
        else if (state_q == IDLE && access && hit && is_st)
            data_q[idx][woff] <= merged;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed and random checks of dcache_wb against a flat-memory reference model
module tb_dcache_wb;
    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] WriteData = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] output_data;
    logic        stall;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] mem_back [logic [31:0]];
    logic [31:0] arch     [logic [31:0]];
    logic        dv [16];
    logic        dd [16];
    logic [23:0] dt [16];
    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic [31:0] last_data;
    int          last_n;

    dcache_wb dut (
        .clk(clk), .reset(reset), .addr(addr), .MemWrite(MemWrite), .MemRead(MemRead),
        .WriteData(WriteData), .funct3(funct3), .output_data(output_data), .stall(stall),
        .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] wa);
        return (wa < 32'h40) ? 32'h1000 + {30'b0, wa[1:0]} : (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] rd_back(input logic [31:0] wa);
        return mem_back.exists(wa) ? mem_back[wa] : dflt(wa);
    endfunction

    function automatic logic [31:0] rd_arch(input logic [31:0] wa);
        return arch.exists(wa) ? arch[wa] : dflt(wa);
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] ln);
        logic [31:0] s;
        s = w >> (8 * ln);
        case (f3)
            3'b000: return {{24{s[7]}}, s[7:0]};
            3'b001: return {{16{s[15]}}, s[15:0]};
            3'b010: return w;
            3'b100: return {24'b0, s[7:0]};
            3'b101: return {16'b0, s[15:0]};
            default: return 32'b0;
        endcase
    endfunction

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    task automatic model_reset();
        arch.delete();
        foreach (mem_back[k]) arch[k] = mem_back[k];
        for (int i = 0; i < 16; i++) begin
            dv[i] = 1'b0;
            dd[i] = 1'b0;
            dt[i] = '0;
        end
    endtask

    task automatic run(input logic we, input logic re, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input int gap);
        logic        st, ld, ok, mis, go, done, waiting;
        logic [31:0] exp_data, w, hold_addr;
        logic [23:0] tg;
        int          ix, exp_n, n, cnt, unstable;
        st = we;
        ld = re & ~we;
        ok = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : 1'b0;
        mis = ok && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00));
        go = ok && !mis;
        ix = int'(a[7:4]);
        tg = a[31:8];
        exp_q.delete();
        exp_n = 0;
        exp_data = '0;
        if (go && !(dv[ix] && dt[ix] == tg)) begin
            if (dv[ix] && dd[ix])
                for (int k = 0; k < 4; k++)
                    exp_q.push_back('{1'b1, {dt[ix], a[7:4], 4'(k * 4)}, rd_arch({dt[ix], a[7:4], 2'(k)})});
            for (int k = 0; k < 4; k++)
                exp_q.push_back('{1'b0, {tg, a[7:4], 4'(k * 4)}, 32'b0});
            exp_n = exp_q.size() * gap + 1;
            dv[ix] = 1'b1;
            dt[ix] = tg;
            dd[ix] = 1'b0;
        end
        if (go && st) begin
            w = rd_arch(a >> 2);
            case (f3)
                3'b000: w[8 * a[1:0] +: 8] = wd[7:0];
                3'b001: w[16 * a[1] +: 16] = wd[15:0];
                default: w = wd;
            endcase
            arch[a >> 2] = w;
            dd[ix] = 1'b1;
        end
        if (go && ld) exp_data = ext(rd_arch(a >> 2), f3, a[1:0]);
        addr = a;
        MemWrite = we;
        MemRead = re;
        funct3 = f3;
        WriteData = wd;
        got_q.delete();
        n = 0;
        cnt = 0;
        unstable = 0;
        waiting = 1'b0;
        hold_addr = '0;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
            n++;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (waiting && mem_addr !== hold_addr) unstable++;
                cnt++;
                if (cnt >= gap) begin
                    cnt = 0;
                    waiting = 1'b0;
                    mem_ack = 1'b1;
                    got_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : 32'b0});
                    if (mem_we) mem_back[mem_addr >> 2] = mem_wdata;
                    else mem_rdata = rd_back(mem_addr >> 2);
                end else begin
                    waiting = 1'b1;
                    hold_addr = mem_addr;
                end
            end
        end
        mem_ack = 1'b0;
        last_data = output_data;
        last_n = n;
        chk("done", 32'(done), 32'd1);
        chk("stall_cycles", n, exp_n);
        chk("output_data", output_data, exp_data);
        chk("misaligned", 32'(misaligned), 32'(mis));
        chk("addr_stable", unstable, 0);
        chk("beat_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            chk("beat_we", 32'(got_q[k].we), 32'(exp_q[k].we));
            chk("beat_addr", got_q[k].a, exp_q[k].a);
            chk("beat_data", got_q[k].d, exp_q[k].d);
        end
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        chk("req_after", 32'(mem_req), 32'd0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_data", output_data, 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run(0, 1, 32'h40, 3'b010, 0, 1);
        chk("tp_lw40", last_data, 32'h00001000);
        chk("tp_lw40_stall", last_n, 5);
        run(0, 1, 32'h44, 3'b010, 0, 1);
        chk("tp_lw44_hit", last_n, 0);

        run(1, 0, 32'h41, 3'b000, 32'h000000AB, 1);
        run(0, 1, 32'h41, 3'b000, 0, 1);
        chk("tp_lb", last_data, 32'hFFFFFFAB);
        run(0, 1, 32'h41, 3'b100, 0, 1);
        chk("tp_lbu", last_data, 32'h000000AB);
        run(0, 1, 32'h40, 3'b010, 0, 1);
        chk("tp_lw_merged", last_data, 32'h0000AB00);
        run(0, 1, 32'h40, 3'b001, 0, 1);
        chk("tp_lh", last_data, 32'hFFFFAB00);

        run(0, 1, 32'h440, 3'b010, 0, 1);
        chk("tp_evict_stall", last_n, 9);
        chk("tp_wb0", got_q.size() > 0 ? got_q[0].d : 32'hDEADDEAD, 32'h0000AB00);
        run(0, 1, 32'h40, 3'b001, 0, 1);
        chk("tp_after_evict", last_data, 32'hFFFFAB00);

        run(0, 1, 32'h42, 3'b010, 0, 1);
        run(0, 1, 32'h43, 3'b001, 0, 1);
        run(1, 0, 32'h45, 3'b001, 32'h1234, 1);

        run(0, 1, 32'h80, 3'b010, 0, 3);
        chk("tp_gap_stall", last_n, 13);
        run(0, 1, 32'h80, 3'b011, 0, 1);
        run(1, 1, 32'h84, 3'b010, 32'hCAFEF00D, 1);
        run(0, 1, 32'h84, 3'b010, 0, 1);
        chk("tp_both_store", last_data, 32'hCAFEF00D);

        addr = 32'hC0;
        MemRead = 1'b1;
        funct3 = 3'b010;
        @(negedge clk);
        chk("mid_miss_stall", 32'(stall), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mid_req", 32'(mem_req), 32'd1);
            mem_ack = 1'b1;
            mem_rdata = rd_back(mem_addr >> 2);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        reset = 1'b1;
        MemRead = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        run(0, 1, 32'hC0, 3'b010, 0, 1);
        chk("refetch_stall", last_n, 5);

        for (int i = 0; i < 150; i++) begin
            logic        we, re;
            logic [2:0]  f3;
            logic [1:0]  ln;
            logic [31:0] a;
            int          r;
            r = $urandom_range(0, 9);
            we = r >= 6;
            re = r < 6 || r == 9;
            f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            if (!we && f3 == 3'd3) f3 = 3'd4;
            if (!we && f3 == 3'd4 && r[0]) f3 = 3'd5;
            ln = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) != 0)
                ln = f3[1:0] == 2'b00 ? ln : f3[1:0] == 2'b01 ? {ln[1], 1'b0} : 2'b00;
            a = (32'($urandom_range(4, 7)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | {30'b0, ln};
            run(we, re, a, f3, $urandom, int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Parametrised successor to the single-cycle data cache.
- Direct-mapped, write-back, write-allocate, with configurable line count and line size.
- Supports RISC-V byte, halfword and word loads and stores, selected by funct3, with sign or zero extension.
- Fills and evicts over a word-serial req/ack memory port and stalls the pipeline on a miss.

Parameters:
- ADDR_WIDTH, 32: byte-address width.
- NUM_LINES, 16: cache lines; power of 2, at least 2.
- LINE_WORDS, 4: 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  ADDR_WIDTH  byte address of the access.
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- WriteData  in  32  store data; byte/half taken from the low bits.
- funct3  in  3  access size and sign mode.
- output_data  out  32  load result, already extended.
- stall  out  1  pipeline must hold addr, control and data.
- misaligned  out  1  access ignored because of misalignment.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDR_WIDTH  word-aligned beat address.
- mem_wdata  out  32  write-beat data.
- mem_rdata  in  32  read-beat data; valid when mem_ack = 1.
- mem_ack  in  1  beat completes this cycle.

Behaviour:
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:0].
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- Per-line state: valid bit, dirty bit, tag, LINE_WORDS words of 32-bit data.
- Reset:
  - All valid and dirty bits cleared.
  - FSM returns to IDLE; beat counter = 0.
  - mem_req = 0, stall = 0, output_data = 0, misaligned = 0.
  - Reset asserted mid-transaction aborts it immediately; the partially filled line stays invalid.
- funct3 on loads:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - Any other code returns 0.
- funct3 on stores:
  - 000 SB, 001 SH, 010 SW.
  - Any other code: no write.
- Byte lane = addr[1:0]; half lane = addr[1].
- Alignment:
  - Half with addr[0] = 1 is misaligned.
  - Word with addr[1:0] != 0 is misaligned.
  - On a misaligned access: misaligned = 1 (combinational), no lookup, stall = 0, output_data = 0, no state change.
- MemRead and MemWrite both high: treated as a store; output_data = 0.
- Neither high: output_data = 0, stall = 0.
- Hit (valid and tag match):
  - Load: output_data is combinational in the same cycle; stall = 0.
  - Store: merges bytes into the line at the clock edge and sets dirty; stall = 0.
- Miss:
  - stall = 1 combinationally in the miss cycle, and stays high until the hit cycle.
  - From IDLE, go to WRITEBACK if the victim is valid and dirty, otherwise REFILL.
- WRITEBACK:
  - mem_req = 1, mem_we = 1.
  - mem_addr = {victim tag, index, beat, 2'b00}; mem_wdata = victim word[beat].
  - On mem_ack, beat increments.
  - After the last beat: clear dirty, beat = 0, go to REFILL.
- REFILL:
  - mem_req = 1, mem_we = 0.
  - mem_addr = {new tag, index, beat, 2'b00}.
  - On mem_ack, write mem_rdata to word[beat] and increment beat.
  - After the last beat: write tag, set valid, clear dirty, go to IDLE.
- Back in IDLE the held access hits; a pending store completes and sets dirty in that cycle.
- Memory port rules:
  - mem_req is registered-state driven and held high until mem_ack.
  - mem_addr and mem_wdata stay stable while mem_req = 1 and mem_ack = 0.
  - mem_ack outside a request is ignored.
- Latency:
  - Clean miss: LINE_WORDS acks plus 1 cycle.
  - Dirty miss: 2 × LINE_WORDS acks plus 1 cycle.
- Beat counter wraps to 0 after the last beat of each phase.
- Request inputs are sampled only in IDLE; changes during stall are a protocol violation and not checked.

Test Plan:
- Reset, then LW at 0x00000040 with a memory model returning word n = 0x1000+n (ack every cycle):
  - 4 read beats to 0x40, 0x44, 0x48, 0x4C.
  - stall high for 5 cycles, then output_data = 0x00001000.
  - Following LW at 0x44 hits with stall = 0.
- SB 0xAB to 0x41 after the fill above, then loads:
  - LB at 0x41 gives 0xFFFFFFAB.
  - LBU gives 0x000000AB.
  - LW at 0x40 gives 0x0000AB00 (line was 0x00001000).
  - LH at 0x40 gives 0xFFFFAB00.
- Dirty eviction: after the SB above, LW at 0x440 (same index, NUM_LINES = 16):
  - 4 write beats to 0x40..0x4C, first beat data 0x0000AB00.
  - Then 4 read beats to 0x440..0x44C, then hit.
- Misaligned: LW at 0x42 and LH at 0x43:
  - misaligned = 1, output_data = 0, stall = 0, mem_req never rises.
- Ack gaps: memory acks every 3rd cycle during a refill:
  - mem_addr holds steady between acks; stall lasts 13 cycles.
- Reset after 2 of 4 refill beats:
  - Next cycle mem_req = 0 and stall = 0.
  - A later LW at the same address misses again and performs a full 4-beat refill.
